vec_mul_seq_ctrl: RTL
=====================

Name: vec_mul_seq_ctrl

Overview:
- Parametrised sequencer that runs one vector-matrix multiply job end to end: weight fetch, weight reload, input vector streaming, pipeline-latency tracking and result write-back.
- Replaces the fixed 16-lane counter/state-machine glue around the systolic array.
- Sits between the unified buffer SRAM, weight SRAM, vec_mul array and result SRAM.
- Drives their address and enable pins from a start/busy/done handshake.

Parameters:
- MATRIX_SIZE, 16, array lanes; informational, bounds PIPE_LATENCY check.
- UB_AW, 10, unified buffer address width.
- RES_AW, 10, result SRAM address width.
- W_AW, 2, weight SRAM address width.
- CNT_W, 10, width of vector-count field.
- PIPE_LATENCY, 18, cycles from ub_rd_en to array result valid (SRAM read + array); legal range 1..63.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- abort  in  1  synchronous job cancel
- num_vec  in  CNT_W  vectors in job, sampled at start
- ub_base  in  UB_AW  first input address, sampled at start
- res_base  in  RES_AW  first result address, sampled at start
- w_sel  in  W_AW  weight SRAM word, sampled at start
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- w_rd_en  out  1  weight SRAM read strobe
- w_addr  out  W_AW  weight SRAM address
- weight_reload  out  1  array weight latch pulse
- ub_rd_en  out  1  unified buffer read strobe
- ub_addr  out  UB_AW  unified buffer address
- res_we  out  1  result SRAM write enable
- res_addr  out  RES_AW  result SRAM address

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all outputs registered and 0; state IDLE; valid shift register cleared.
- States: IDLE -> WFETCH -> WLOAD -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 with num_vec>0 latches parameters and goes to WFETCH.
  - start=1 with num_vec=0 goes directly to DONE; no SRAM strobes issued.
- WFETCH (1 cycle): w_rd_en=1, w_addr=w_sel.
- WLOAD (1 cycle): weight_reload=1.
- STREAM (num_vec cycles):
  - ub_rd_en=1; ub_addr=ub_base+k for k=0..num_vec-1.
  - Address wraps modulo 2^UB_AW.
- Valid tracking: each issued read pushes a 1 into a PIPE_LATENCY-deep valid shift register. At its tail: res_we=1, res_addr=res_base+j, j counting writes from 0, wrapping modulo 2^RES_AW.
- Result timing: res_we for vector k asserts exactly PIPE_LATENCY cycles after the cycle ub_rd_en issued it.
- DRAIN: entered after the last read; stays until the shift register is empty and the final res_we cycle has passed.
- DONE (1 cycle): done=1, then IDLE.
- busy: 1 in every state except IDLE, including the DONE cycle.
- start while busy is ignored. Inputs are not re-sampled mid-job.
- abort=1 in any non-IDLE state:
  - Next cycle returns to IDLE.
  - Clears the shift register; no further res_we.
  - done is not pulsed.
  - abort in IDLE has no effect.
- abort and start together in IDLE: start wins.
- Reset mid-job: immediate return to IDLE, all strobes 0.
- Write counter and read counter are independent: a write may coincide with a read in STREAM.

Optional Feature:
- Macro: VEC_MUL_SEQ_CYCLE_COUNT_EN.
- Enabled:
  - Adds output cycle_count [15:0].
  - Cleared on job start; increments every busy cycle; saturates at 16'hFFFF.
  - Holds its value after done until the next start; reset value 0.
- Disabled: port and counter absent; all other behaviour identical.

Test Plan:
- Basic job: reset, then start with num_vec=4, ub_base=0x010, res_base=0x020, w_sel=2, PIPE_LATENCY=18.
  - w_rd_en at cycle 1 (w_addr=2); weight_reload at cycle 2.
  - ub_rd_en cycles 3-6 (addr 0x010-0x013).
  - res_we cycles 21-24 (addr 0x020-0x023).
  - done at cycle 25; busy cycles 1-25.
- Zero-length job: start with num_vec=0 -> done pulses cycle 1, busy high that cycle only; no w_rd_en, ub_rd_en or res_we.
- Wrap-around: ub_base=0x3FE, res_base=0x3FF, num_vec=3 -> ub_addr 0x3FE, 0x3FF, 0x000; res_addr 0x3FF, 0x000, 0x001.
- Abort mid-pipeline: num_vec=8, abort at cycle 12 -> IDLE at cycle 13; zero res_we from cycle 13 on; done never asserts. A following job runs normally.
- Start while busy: second start at cycle 5 of a num_vec=4 job -> ignored; exactly 4 res_we, one done pulse.
- With VEC_MUL_SEQ_CYCLE_COUNT_EN, basic job -> cycle_count=25 after done, held until next start.

Source files
------------

// File: rtl/vec_mul_seq_ctrl.sv
// ============================================================================
// vec_mul_seq_ctrl : weight fetch / reload / vector stream / result write-back
// sequencer for one vector-matrix job. Optional: VEC_MUL_SEQ_CYCLE_COUNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module vec_mul_seq_ctrl #(
  parameter int MATRIX_SIZE  = 16,
  parameter int UB_AW        = 10,
  parameter int RES_AW       = 10,
  parameter int W_AW         = 2,
  parameter int CNT_W        = 10,
  parameter int PIPE_LATENCY = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [UB_AW-1:0]  ub_base,
  input  logic [RES_AW-1:0] res_base,
  input  logic [W_AW-1:0]   w_sel,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_addr,
  output logic              weight_reload,
  output logic              ub_rd_en,
  output logic [UB_AW-1:0]  ub_addr,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr
`ifdef VEC_MUL_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFETCH = 3'd1,
    S_WLOAD  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_vec_left;
  logic [PIPE_LATENCY-1:0] r_valid_sr;
  logic [PIPE_LATENCY-1:0] w_sr_next;
  logic                    w_sr_pending;
  logic [RES_AW-1:0]       r_res_ptr;

  if (PIPE_LATENCY < 1 || PIPE_LATENCY > 63 || MATRIX_SIZE < 1) begin : g_bad_param
    $error("vec_mul_seq_ctrl: PIPE_LATENCY must be 1..63");
  end

  // Bit i of the valid shift register is a read issued i+1 cycles ago, so the
  // MSB lines up exactly PIPE_LATENCY cycles after the ub_rd_en cycle.
  if (PIPE_LATENCY > 1) begin : g_sr_deep
    assign w_sr_next    = {r_valid_sr[PIPE_LATENCY-2:0], ub_rd_en};
    assign w_sr_pending = |r_valid_sr[PIPE_LATENCY-2:0];
  end else begin : g_sr_single
    assign w_sr_next    = ub_rd_en;
    assign w_sr_pending = 1'b0;
  end

  assign res_we   = r_valid_sr[PIPE_LATENCY-1];
  assign res_addr = r_res_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      weight_reload <= 1'b0;
      ub_rd_en      <= 1'b0;
      ub_addr       <= '0;
      r_vec_left    <= '0;
      r_valid_sr    <= '0;
      r_res_ptr     <= '0;
    end else begin
      r_valid_sr    <= w_sr_next;
      if (res_we) begin
        r_res_ptr <= r_res_ptr + RES_AW'(1);
      end
      w_rd_en       <= 1'b0;
      weight_reload <= 1'b0;
      done          <= 1'b0;

      if (r_state != S_IDLE && abort) begin
        r_state    <= S_IDLE;
        busy       <= 1'b0;
        ub_rd_en   <= 1'b0;
        r_valid_sr <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              busy       <= 1'b1;
              w_addr     <= w_sel;
              ub_addr    <= ub_base;
              r_res_ptr  <= res_base;
              r_vec_left <= num_vec - CNT_W'(1);
              if (num_vec == '0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_WFETCH;
                w_rd_en <= 1'b1;
              end
            end
          end
          S_WFETCH: begin
            r_state       <= S_WLOAD;
            weight_reload <= 1'b1;
          end
          S_WLOAD: begin
            r_state  <= S_STREAM;
            ub_rd_en <= 1'b1;
          end
          S_STREAM: begin
            if (r_vec_left == '0) begin
              r_state  <= S_DRAIN;
              ub_rd_en <= 1'b0;
            end else begin
              ub_addr    <= ub_addr + UB_AW'(1);
              r_vec_left <= r_vec_left - CNT_W'(1);
            end
          end
          S_DRAIN: begin
            // Only the MSB may still be set here; that write is this cycle.
            if (!w_sr_pending) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            ub_rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VEC_MUL_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_count <= '0;
    end else if (r_state == S_IDLE && start) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
